uart_link_arbiter: RTL and testbench
====================================

// Module: uart_link_arbiter
// PURPOSE
//  Shares the single UART tx/rx link between two masters: client 0 (instruction fetch) and
//  client 1 (load/store unit). Grants the link to one client for a whole transaction
//  (flag, address, data bytes), muxes that client's tx onto the UART and routes rx/tx_done back.
//  Round-robin arbitration; one-cycle release gap between grants.
// PARAMETERS
//  TIMEOUT_CYCLES  100000  watchdog limit: idle cycles inside a grant before forced release
//  WD_W            17      watchdog counter width; must satisfy 2**WD_W >= TIMEOUT_CYCLES
// PORTS
//  clk            in   1  system clock
//  reset          in   1  synchronous, active-high reset
//  req0, req1     in   1  client requests link; held high until the client's done is seen
//  done0, done1   in   1  client transaction complete (1-cycle pulse)
//  tx_start_n0/1  in   1  client tx start, active-low (1 = idle)
//  tx_data0/1     in   8  client tx byte
//  gnt0, gnt1     out  1  registered grant, one-hot or zero
//  tx_done0/1     out  1  UART tx_done routed to the granted client, else 0
//  rx_do0/1       out  1  UART rx_do routed to the granted client, else 0
//  rx_data_out    out  8  UART rx_data passthrough (valid only with rx_doN)
//  tx_start_n_out out  1  to UART transmitter, active-low
//  tx_data_out    out  8  to UART transmitter
//  tx_done, rx_do in   1  from UART
//  rx_data        in   8  from UART
//  stray_rx       out  1  sticky: rx_do seen while no client granted
//  timeout        out  1  1-cycle pulse on watchdog forced release
// BEHAVIOUR
//  Reset: state IDLE, last=1 (client 0 wins first tie), gnt0=gnt1=0, tx_start_n_out=1,
//   tx_data_out=0, tx_done0/1=rx_do0/1=0, stray_rx=0, timeout=0, watchdog=0.
//  Reset mid-grant: next cycle IDLE, grants drop; in-flight UART byte's tx_done/rx_do ignored.
//  FSM: IDLE -> GNT0 | GNT1 -> REL -> IDLE.
//  IDLE: req0&req1 -> grant client != last; single req -> grant it; none -> stay.
//   gnt rises the cycle after req is sampled (1-cycle latency); last <= granted id.
//  GNTn: tx_start_n_out=tx_start_n<n>, tx_data_out=tx_data<n> (combinational mux, 0 latency);
//   other client's tx inputs ignored; tx_done/rx_do routed combinationally to client n only.
//   Exit to REL when done<n>=1 or req<n>=0 (both same cycle: single release).
//  REL: one cycle, gnt0=gnt1=0, tx_start_n_out=1, tx_data_out=0; then IDLE.
//   Guarantees alternation under continuous requests: 0,1,0,1...
//  Outside GNTn: tx_start_n_out=1, tx_data_out=0, all routed strobes 0.
//  stray_rx: set when rx_do=1 in IDLE or REL; cleared only by reset.
//  done<n> from the non-granted client: ignored.
// CONFIGURATION
//  UART_ARB_WDOG_EN defined: watchdog cleared on grant entry and on any tx_done or rx_do;
//   increments each GNTn cycle; at TIMEOUT_CYCLES-1 -> REL, timeout=1 for one cycle.
//  Undefined: no counter, timeout tied 0, grant held until done/req drop.
// TESTING
//  req0 only, 2 bytes 0x01,0x22, done0 -> gnt0 1 cycle after req0; tx_data_out tracks; REL 1 cycle.
//  req0&req1 rise same cycle after reset -> gnt0 first; after done0 + REL -> gnt1; again -> gnt0.
//  gnt1 active, rx_do=1 rx_data=0xA5 -> rx_do1=1, rx_do0=0, rx_data_out=0xA5.
//  rx_do=1 in IDLE -> stray_rx=1 and stays 1 until reset; no client sees rx_do.
//  reset=1 mid-GNT0 during byte -> next cycle gnt0=0, tx_start_n_out=1, late tx_done not routed.
//  UART_ARB_WDOG_EN, TIMEOUT_CYCLES=16: gnt0 with no activity -> REL, timeout pulse; gnt1 can follow.

Source files
------------

// File: rtl/uart_link_arbiter.sv
// Round-robin arbiter sharing one UART tx/rx link between instruction fetch (client 0) and load/store (client 1).
// Optional watchdog forced release is enabled by defining UART_ARB_WDOG_EN.
module uart_link_arbiter #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int WD_W           = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       done0,
  input  logic       done1,
  input  logic       tx_start_n0,
  input  logic       tx_start_n1,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       tx_done0,
  output logic       tx_done1,
  output logic       rx_do0,
  output logic       rx_do1,
  output logic [7:0] rx_data_out,
  output logic       tx_start_n_out,
  output logic [7:0] tx_data_out,
  input  logic       tx_done,
  input  logic       rx_do,
  input  logic [7:0] rx_data,
  output logic       stray_rx,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    REL  = 2'd3
  } state_t;

  if (2**WD_W < TIMEOUT_CYCLES) begin : g_bad_wd_w
    $error("WD_W too narrow for TIMEOUT_CYCLES");
  end

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last;
  logic   r_stray;
  logic   w_in_gnt;
  logic   w_wd_expire;

  assign w_in_gnt = (r_state == GNT0) || (r_state == GNT1);

`ifdef UART_ARB_WDOG_EN
  logic [WD_W-1:0] r_wd;
  logic            r_timeout;

  // Any UART activity proves the granted client is alive and restarts the count.
  assign w_wd_expire = w_in_gnt && !(tx_done || rx_do) &&
                       (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wd_expire;
      if (!w_in_gnt || tx_done || rx_do)
        r_wd <= '0;
      else
        r_wd <= r_wd + 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_wd_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_stray <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_state_nxt == GNT0)
        r_last <= 1'b0;
      else if (r_state == IDLE && w_state_nxt == GNT1)
        r_last <= 1'b1;
      if (rx_do && !w_in_gnt)
        r_stray <= 1'b1;
    end
  end

  // On a tie the client that did not hold the previous grant wins.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req0 && (!req1 || r_last))
          w_state_nxt = GNT0;
        else if (req1)
          w_state_nxt = GNT1;
      end
      GNT0: if (done0 || !req0 || w_wd_expire) w_state_nxt = REL;
      GNT1: if (done1 || !req1 || w_wd_expire) w_state_nxt = REL;
      REL:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_start_n_out = 1'b1;
    tx_data_out    = 8'h00;
    tx_done0       = 1'b0;
    tx_done1       = 1'b0;
    rx_do0         = 1'b0;
    rx_do1         = 1'b0;
    if (r_state == GNT0) begin
      tx_start_n_out = tx_start_n0;
      tx_data_out    = tx_data0;
      tx_done0       = tx_done;
      rx_do0         = rx_do;
    end else if (r_state == GNT1) begin
      tx_start_n_out = tx_start_n1;
      tx_data_out    = tx_data1;
      tx_done1       = tx_done;
      rx_do1         = rx_do;
    end
  end

  assign gnt0        = (r_state == GNT0);
  assign gnt1        = (r_state == GNT1);
  assign rx_data_out = rx_data;
  assign stray_rx    = r_stray;

endmodule

// File: tb/tb_uart_link_arbiter.sv
// Directed bench for uart_link_arbiter: grants, round-robin order, routing, stray rx, reset, watchdog.
module tb_uart_link_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, done0, done1;
  logic       tx_start_n0, tx_start_n1;
  logic [7:0] tx_data0, tx_data1;
  logic       gnt0, gnt1, tx_done0, tx_done1, rx_do0, rx_do1;
  logic [7:0] rx_data_out, tx_data_out, rx_data;
  logic       tx_start_n_out, tx_done, rx_do, stray_rx, timeout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_link_arbiter #(.TIMEOUT_CYCLES(16), .WD_W(5)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .done0(done0), .done1(done1),
    .tx_start_n0(tx_start_n0), .tx_start_n1(tx_start_n1),
    .tx_data0(tx_data0), .tx_data1(tx_data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .tx_done0(tx_done0), .tx_done1(tx_done1),
    .rx_do0(rx_do0), .rx_do1(rx_do1), .rx_data_out(rx_data_out),
    .tx_start_n_out(tx_start_n_out), .tx_data_out(tx_data_out),
    .tx_done(tx_done), .rx_do(rx_do), .rx_data(rx_data),
    .stray_rx(stray_rx), .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int k;
    logic saw_to;
    reset = 1'b1; req0 = 0; req1 = 0; done0 = 0; done1 = 0;
    tx_start_n0 = 1; tx_start_n1 = 1; tx_data0 = 0; tx_data1 = 0;
    tx_done = 0; rx_do = 0; rx_data = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_txsn", tx_start_n_out, 1);
    chk("rst_txd", tx_data_out, 8'h00);
    chk("rst_stray", stray_rx, 0);
    chk("rst_timeout", timeout, 0);

    // single client 0 transaction, client 1 tx inputs must be ignored
    req0 = 1; tx_start_n0 = 0; tx_data0 = 8'h01; tx_start_n1 = 0; tx_data1 = 8'h77;
    #1;
    chk("idle_gnt0", gnt0, 0);
    chk("idle_txsn", tx_start_n_out, 1);
    tick();
    chk("t1_gnt0", gnt0, 1);
    chk("t1_gnt1", gnt1, 0);
    chk("t1_txsn", tx_start_n_out, 0);
    chk("t1_byte0", tx_data_out, 8'h01);
    tx_data0 = 8'h22; tx_done = 1;
    #1;
    chk("t1_byte1", tx_data_out, 8'h22);
    chk("t1_txdone0", tx_done0, 1);
    chk("t1_txdone1", tx_done1, 0);
    tick();
    tx_done = 0; done0 = 1; tx_start_n0 = 1;
    #1;
    chk("t1_hold", gnt0, 1);
    tick();
    done0 = 0; req0 = 0; tx_start_n1 = 1; tx_data1 = 0;
    chk("t1_rel_gnt0", gnt0, 0);
    chk("t1_rel_txsn", tx_start_n_out, 1);
    chk("t1_rel_txd", tx_data_out, 8'h00);
    tick();
    chk("t1_idle_gnt0", gnt0, 0);

    // tie after reset: 0, then 1, then 0
    reset = 1; tick(); reset = 0;
    req0 = 1; req1 = 1;
    tick();
    chk("rr_first_gnt0", gnt0, 1);
    chk("rr_first_gnt1", gnt1, 0);
    done0 = 1;
    tick();
    done0 = 0;
    chk("rr_rel_gnt0", gnt0, 0);
    chk("rr_rel_gnt1", gnt1, 0);
    tick();
    chk("rr_idle_gnt1", gnt1, 0);
    tick();
    chk("rr_second_gnt1", gnt1, 1);
    chk("rr_second_gnt0", gnt0, 0);
    rx_do = 1; rx_data = 8'hA5; done0 = 1;
    #1;
    chk("rx_do1", rx_do1, 1);
    chk("rx_do0", rx_do0, 0);
    chk("rx_data", rx_data_out, 8'hA5);
    tick();
    rx_do = 0; done0 = 0;
    chk("foreign_done", gnt1, 1);
    done1 = 1;
    tick();
    done1 = 0;
    chk("rr_rel2_gnt1", gnt1, 0);
    tick(); tick();
    chk("rr_third_gnt0", gnt0, 1);
    chk("no_stray_yet", stray_rx, 0);

    // reset mid-byte during GNT0
    req1 = 0; tx_start_n0 = 0; tx_data0 = 8'h5A;
    #1;
    chk("mid_txsn", tx_start_n_out, 0);
    chk("mid_txd", tx_data_out, 8'h5A);
    reset = 1;
    tick();
    reset = 0; tx_done = 1; req0 = 0; tx_start_n0 = 1;
    #1;
    chk("rst_mid_gnt0", gnt0, 0);
    chk("rst_mid_txsn", tx_start_n_out, 1);
    chk("rst_mid_txdone0", tx_done0, 0);
    tick();
    tx_done = 0;

    // stray rx in IDLE
    rx_do = 1; rx_data = 8'h3C;
    #1;
    chk("stray_rx_do0", rx_do0, 0);
    chk("stray_rx_do1", rx_do1, 0);
    tick();
    rx_do = 0;
    chk("stray_set", stray_rx, 1);
    tick(); tick(); tick();
    chk("stray_sticky", stray_rx, 1);
    reset = 1; tick(); reset = 0;
    chk("stray_clr", stray_rx, 0);

    // idle grant: watchdog release when enabled, held otherwise
    req0 = 1;
    tick();
    chk("wd_gnt0", gnt0, 1);
    req1 = 1;
`ifdef UART_ARB_WDOG_EN
    k = 0;
    saw_to = 0;
    while (gnt0 && k < 40) begin
      saw_to = saw_to | timeout;
      tick();
      k++;
    end
    req0 = 0;
    chk("wd_len", 8'(k), 8'd16);
    chk("wd_early_to", saw_to, 0);
    chk("wd_pulse", timeout, 1);
    tick();
    chk("wd_pulse_end", timeout, 0);
    tick();
    chk("wd_next_gnt1", gnt1, 1);
`else
    saw_to = 0;
    for (int i = 0; i < 20; i++) begin
      saw_to = saw_to | timeout;
      tick();
    end
    chk("nowd_held", gnt0, 1);
    chk("nowd_timeout", saw_to, 0);
    req0 = 0;
    tick();
    chk("reqdrop_rel", gnt0, 0);
    tick(); tick();
    chk("reqdrop_next_gnt1", gnt1, 1);
`endif
    req0 = 0; req1 = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
